// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: a two-word register window (TXDATA, STATUS) feeding a small
// byte FIFO that an FSM serialises onto tx as 8N1 frames, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL_COUNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } stateType;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;
  logic          overflow;
  stateType      state;
  logic [BW-1:0] baudCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          txReg;
`ifdef UART_TX_PARITY_EN
  logic          parityBit;
`endif

  logic       wrTxData, wrStatus, fifoFull, fifoEmpty, baudDone, pop, pushOk, txActive;
  logic [7:0] headByte;
  logic [31:0] status;
  logic       unusedBits;

  assign hit       = (DataAdr[31:3] == BASE_ADDR[31:3]);
  assign wrTxData  = hit && MemWrite && !DataAdr[2];
  assign wrStatus  = hit && MemWrite && DataAdr[2];
  assign fifoFull  = (count == FULL_COUNT);
  assign fifoEmpty = (count == '0);
  assign baudDone  = (baudCnt == '0);
  assign txActive  = (state != IDLE);
  assign headByte  = fifoMem[rdPtr];
  assign unusedBits = ^{WriteData[31:8], DataAdr[1:0]};

  // A pop happens when the FSM starts a frame, either from IDLE or straight out of STOP.
  assign pop    = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudDone));
  assign pushOk = wrTxData && (!fifoFull || pop);

  assign status   = {23'b0, 5'(count), overflow, txActive, fifoEmpty, fifoFull};
  assign ReadData = (hit && MemRead && DataAdr[2]) ? status : 32'h0;
  assign busy     = txActive || !fifoEmpty;
  assign tx       = txReg;

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      case ({pushOk, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
      if (wrTxData && fifoFull && !pop)  overflow <= 1'b1;
      else if (wrStatus && WriteData[3]) overflow <= 1'b0;
    end
  end

  // Data path: the shift register always presents the bit on the wire at bit 0.
  always_ff @(posedge clk) begin
    if (pop) begin
      shiftReg <= headByte;
`ifdef UART_TX_PARITY_EN
      parityBit <= ^headByte;
`endif
    end else if ((state == DATA) && baudDone && (bitCnt != 3'd7)) begin
      shiftReg <= shiftReg >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baudCnt <= '0;
      bitCnt  <= '0;
      txReg   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            state   <= START;
            txReg   <= 1'b0;
            baudCnt <= BAUD_RELOAD;
            bitCnt  <= '0;
          end
        end
        START: begin
          if (baudDone) begin
            state   <= DATA;
            txReg   <= shiftReg[0];
            baudCnt <= BAUD_RELOAD;
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= BAUD_RELOAD;
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              txReg  <= parityBit;
`else
              state  <= STOP;
              txReg  <= 1'b1;
`endif
            end else begin
              bitCnt <= bitCnt + 3'd1;
              txReg  <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baudDone) begin
            state   <= STOP;
            txReg   <= 1'b1;
            baudCnt <= BAUD_RELOAD;
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            if (!fifoEmpty) begin
              state   <= START;
              txReg   <= 1'b0;
              baudCnt <= BAUD_RELOAD;
            end else begin
              state   <= IDLE;
              txReg   <= 1'b1;
              baudCnt <= '0;
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          txReg   <= 1'b1;
          baudCnt <= '0;
          bitCnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: expected tx waveforms are built from queued bytes as bit lists
// (start, data LSB first, optional even parity, stop), each held CPB cycles.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] DataAdr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic expQ[$];

  uart_tx_mmio #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .hit(hit),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Appends one frame's waveform, one entry per clock, to the expected stream.
  function automatic void queueFrame(input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int c = 0; c < CPB; c++) expQ.push_back(bits[i]);
  endfunction

  function automatic logic [31:0] statusWord(input int cnt, input bit ovf, input bit active);
    logic [31:0] w;
    w = 32'(cnt) << 4;
    w[3] = ovf;
    w[2] = active;
    w[1] = (cnt == 0);
    w[0] = (cnt == DEPTH);
    return w;
  endfunction

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    DataAdr = addr;
    WriteData = data;
    MemWrite = 1'b1;
    @(posedge clk);
    #1 MemWrite = 1'b0;
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [31:0] expData,
                         input logic expHit, input string tag);
    @(negedge clk);
    DataAdr = addr;
    MemRead = 1'b1;
    #1;
    check(tag, ReadData, expData);
    check({tag, "_hit"}, 32'(hit), 32'(expHit));
    MemRead = 1'b0;
  endtask

  // Started alongside the first write: idle cycle before the start edge, then the whole stream.
  task automatic checkStream(input string tag);
    logic b;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_pre"}, 32'(tx), 32'd1);
    while (expQ.size() > 0) begin
      b = expQ.pop_front();
      @(negedge clk);
      check(tag, 32'(tx), 32'(b));
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    check({tag, "_endTx"}, 32'(tx), 32'd1);
    check({tag, "_endBusy"}, 32'(busy), 32'd0);
  endtask

  task automatic waitIdle(input int limit, input string tag);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] rb[6];
    logic [7:0] b0;
    int acc;
    bit ovfExp;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstTx", 32'(tx), 32'd1);
    check("rstBusy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    readReg(BASE + 32'd4, 32'h2, 1'b1, "rstStatus");
    @(negedge clk);
    DataAdr = BASE + 32'd4;
    #1 check("noReadStrobe", ReadData, 32'h0);

    queueFrame(8'hA5);
    fork
      checkStream("a5");
      writeReg(BASE, 32'h0000_00A5);
    join

    queueFrame(8'h55);
    queueFrame(8'h0F);
    fork
      checkStream("b2b");
      begin
        writeReg(BASE, 32'h0000_0055);
        writeReg(BASE, 32'h0000_000F);
      end
    join

    for (int i = 0; i < 3; i++) rb[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) queueFrame(rb[i]);
    fork
      checkStream("rand");
      for (int i = 0; i < 3; i++) writeReg(BASE, {$urandom_range(255, 0) << 8, rb[i]});
    join

    b0 = 8'($urandom);
    for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
    queueFrame(b0);
    acc = 0;
    ovfExp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (acc < DEPTH) begin
        queueFrame(rb[i]);
        acc++;
      end else begin
        ovfExp = 1'b1;
      end
    end
    fork
      checkStream("ovf");
      begin
        writeReg(BASE, {24'h0, b0});
        repeat (3) @(posedge clk);
        for (int i = 0; i < 6; i++) writeReg(BASE, {24'h0, rb[i]});
        readReg(BASE + 32'd4, statusWord(acc, ovfExp, 1'b1), 1'b1, "ovfStatus");
        writeReg(BASE + 32'd4, 32'h7);
        readReg(BASE + 32'd4, statusWord(acc, ovfExp, 1'b1), 1'b1, "ovfKeep");
        writeReg(BASE + 32'd4, 32'h8);
        readReg(BASE + 32'd4, statusWord(acc, 1'b0, 1'b1), 1'b1, "ovfClear");
      end
    join

    writeReg(BASE + 32'd8, 32'h33);
    writeReg(32'h0, 32'h44);
    readReg(BASE + 32'd8, 32'h0, 1'b0, "decodeOff8");
    readReg(32'h0, 32'h0, 1'b0, "decodeZero");
    readReg(BASE, 32'h0, 1'b1, "readTxData");
    readReg(BASE + 32'd4, 32'h2, 1'b1, "decodeStatus");
    @(negedge clk);
    check("decodeBusy", 32'(busy), 32'd0);
    check("decodeTx", 32'(tx), 32'd1);

    writeReg(BASE, 32'h81);
    writeReg(BASE, 32'h3C);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstMidTx", 32'(tx), 32'd1);
    check("rstMidBusy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    readReg(BASE + 32'd4, 32'h2, 1'b1, "rstMidStatus");
    repeat (5) @(negedge clk);
    check("rstMidIdle", 32'(tx), 32'd1);

`ifdef UART_TX_PARITY_EN
    queueFrame(8'h07);
    fork
      checkStream("parity");
      writeReg(BASE, 32'h07);
    join
`endif

    waitIdle(200, "drainIdle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the single-cycle core's data port, parallel to the data memory. It decodes `DataAdr`/`MemWrite`/`MemRead` for its own two-word register window and queues written bytes in a small FIFO. An FSM serialises the queued bytes onto `tx` as 8N1 frames (optionally 8E1). The top level uses `hit` to select this block's `ReadData` over the data memory's.

## Interface
- `BASE_ADDR`, 32'h0000_1000, base of the 8-byte register window; bits [2:0] must be zero.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit; minimum 2.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  core store strobe.
- `MemRead`  in  1  core load strobe.
- `DataAdr`  in  32  core data address.
- `WriteData`  in  32  core store data.
- `ReadData`  out  32  register read data (combinational).
- `hit`  out  1  `DataAdr[31:3] == BASE_ADDR[31:3]` (combinational).
- `tx`  out  1  serial output, idle high.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Register map (word offset = `DataAdr[2]`):
  - Offset 0, TXDATA: write pushes `WriteData[7:0]`; a read returns 0.
  - Offset 4, STATUS: read returns bit0 full, bit1 empty, bit2 tx_active (FSM not in IDLE), bit3 overflow (sticky), bits[8:4] FIFO count, other bits 0. A write with `WriteData[3]=1` clears overflow; all other write bits are ignored.
- `ReadData` is `hit & MemRead` ? register : 32'h0.
- Writes with `hit=0` are ignored.
- Push to a full FIFO: byte dropped, overflow set, FIFO unchanged.
- If a push and a pop occur on the same edge while the FIFO is full, the push is accepted and the count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty: pop head into the shift register and drive `tx=0`.
  - START → DATA after `CLKS_PER_BIT` cycles; bits are sent LSB first.
  - DATA holds each bit `CLKS_PER_BIT` cycles. After bit 7, go to PARITY if the parity feature is enabled, else STOP.
  - PARITY drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, then goes to STOP.
  - STOP drives `tx=1` for `CLKS_PER_BIT` cycles. At the end, go to START (popping) if the FIFO is non-empty, else IDLE. Back-to-back frames have no idle gap.
- Baud counter: counts `CLKS_PER_BIT-1` down to 0, reloaded on every state/bit change. Bit counter: 3 bits, 0..7.
- FIFO pointers are log2(`FIFO_DEPTH`) bits and wrap. The count is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- Reset values (asynchronous, while `reset=0`):
  - `tx=1`, `busy=0`, FSM in IDLE, FIFO empty, overflow=0, counters 0.
  - `ReadData` and `hit` are combinational and unaffected by reset.
- Reset mid-frame: `tx` returns high immediately, the frame is aborted and the FIFO contents are discarded.
- Frame sequence from an empty, idle block:
  - TXDATA write sampled at edge N: count=1 after N.
  - Edge N+1: pop, and `tx` falls.
  - Frame length is exactly 10×`CLKS_PER_BIT` cycles (11× with parity).
- `busy` is registered-state derived; it rises the cycle after the accepting edge and falls on the edge that enters IDLE with the FIFO empty.
- The STATUS read reflects state as of the last edge; a same-cycle write is not visible until after the edge.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1, 11 bits.
- Undefined: PARITY state and parity logic are absent, and frames are 8N1, 10 bits.

## Test plan
- Reset: hold `reset=0` mid-frame → `tx=1` and `busy=0` at once; STATUS reads 32'h0000_0002 after release.
- Single byte, `CLKS_PER_BIT`=4: write 8'hA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting the edge after the write.
- Back-to-back: write 8'h55 then 8'h0F → the second start bit immediately follows the first stop bit; `busy` stays high for 80 cycles.
- Overflow, depth 4: five writes while the first frame is still in progress → fifth byte dropped; STATUS bit3=1. Writing STATUS with 32'h8 → bit3=0.
- Decode: write to `BASE_ADDR`+8 or 0 → FIFO unchanged, `hit=0`, `ReadData`=0. Read of `BASE_ADDR` → 0.
- Parity (macro defined): write 8'h07 → parity bit 1; 11-bit frame.
